addr_gen_fft_iter_resp: RTL and testbench

- Address-generation responder for the iterative in-place radix-2 DIT FFT engine; sits on the far side of the FFT control unit's ADDR_EN / ADDR_RST strobes.
- Tracks the layer/butterfly position and produces the two data-RAM addresses (A, B) plus the twiddle-ROM index for the current butterfly.
- The same addresses serve the read and the in-place write-back. Reports layer progress and completion back to the control side.
- Data RAM holds N = 2^LAYERS samples, loaded in bit-reversed order before START.

---
 rtl/addr_gen_fft_iter_resp_if.sv | 33 +++
 rtl/addr_gen_fft_iter_resp.sv | 101 ++++++++++
 tb/tb_addr_gen_fft_iter_resp.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/addr_gen_fft_iter_resp_if.sv
// Control-side bundle for the FFT address generator: advance/clear strobes in, position and addresses out.
// Latency: pure wiring; no state.
// Backpressure: none; the generator accepts a strobe on every enabled clock.
//
// master : FFT control unit (drives EN/ADDR_RST/ADDR_EN, consumes addresses and status)
// slave  : address generator
interface addr_gen_fft_iter_resp_if #(
    parameter int LAYERS = 5,
    parameter int LayWL  = 3,
    parameter int ButtWL = 4
);
    logic              EN;
    logic              ADDR_RST;
    logic              ADDR_EN;
    logic [LAYERS-1:0] ADDR_A;
    logic [LAYERS-1:0] ADDR_B;
    logic [ButtWL-1:0] TW_ADDR;
    logic [LayWL-1:0]  LAY_NUM;
    logic [ButtWL-1:0] BUT_NUM;
    logic              LAY_DONE;
    logic              LAST_LAY;
    logic              DONE;

    modport master (
        output EN, ADDR_RST, ADDR_EN,
        input  ADDR_A, ADDR_B, TW_ADDR, LAY_NUM, BUT_NUM, LAY_DONE, LAST_LAY, DONE
    );

    modport slave (
        input  EN, ADDR_RST, ADDR_EN,
        output ADDR_A, ADDR_B, TW_ADDR, LAY_NUM, BUT_NUM, LAY_DONE, LAST_LAY, DONE
    );
endinterface

// File: rtl/addr_gen_fft_iter_resp.sv
// Address generator for an in-place iterative radix-2 DIT FFT: RAM A/B addresses and twiddle index per butterfly.
// Latency: addresses for the advanced position appear the cycle after the ADDR_EN edge.
// Backpressure: none; EN low freezes all state, ADDR_EN is ignored once DONE is set.
//
// Ports: CLK, RST (async, active low), bus (slave modport):
//   in  EN, ADDR_RST, ADDR_EN
//   out ADDR_A, ADDR_B, TW_ADDR, LAY_NUM, BUT_NUM, LAY_DONE, LAST_LAY, DONE
module addr_gen_fft_iter_resp #(
    parameter int LAYERS      = 5,
    parameter int BUTTERFLYES = 16,
    parameter int LayWL       = 3,
    parameter int ButtWL      = 4
) (
    input  logic                      CLK,
    input  logic                      RST,
    addr_gen_fft_iter_resp_if.slave   bus
);

    logic [LayWL-1:0]  lay_q, lay_d;
    logic [ButtWL-1:0] but_q, but_d;
    logic              done_q, done_d;
    logic              lay_done_q, lay_done_d;

    // Next-state: clear beats advance; the layer-done pulse self-clears on any enabled edge.
    always_comb begin
        lay_d      = lay_q;
        but_d      = but_q;
        done_d     = done_q;
        lay_done_d = 1'b0;
        if (bus.ADDR_RST) begin
            lay_d  = '0;
            but_d  = '0;
            done_d = 1'b0;
        end else if (bus.ADDR_EN && !done_q) begin
            if (but_q != ButtWL'(BUTTERFLYES - 1)) begin
                but_d = but_q + 1'b1;
            end else begin
                but_d      = '0;
                lay_done_d = 1'b1;
                if (lay_q != LayWL'(LAYERS - 1)) begin
                    lay_d = lay_q + 1'b1;
                end else begin
                    done_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            lay_q      <= '0;
            but_q      <= '0;
            done_q     <= 1'b0;
            lay_done_q <= 1'b0;
        end else if (bus.EN) begin
            lay_q      <= lay_d;
            but_q      <= but_d;
            done_q     <= done_d;
            lay_done_q <= lay_done_d;
        end
    end

    // Address decode. In layer l the butterfly index splits into a group part
    // (bits >= l) and an in-group offset (bits < l). Shifting the group part up
    // by one opens a zero at bit l: that is A, and B is A with bit l set.
    // The twiddle index is the offset scaled to the full N/2 twiddle table.
    logic [LAYERS-1:0] but_ext;
    logic [LAYERS-1:0] lo_mask;
    logic [LAYERS-1:0] pos;
    logic [LAYERS-1:0] addr_a;
    logic [LAYERS-1:0] addr_b;
    logic [ButtWL-1:0] tw_addr;

    always_comb begin
        but_ext = LAYERS'(but_q);
        lo_mask = '0;
        pos     = '0;
        addr_a  = '0;
        addr_b  = '0;
        tw_addr = '0;
        for (int l = 0; l < LAYERS; l++) begin
            if (lay_q == LayWL'(l)) begin
                lo_mask = LAYERS'((1 << l) - 1);
                pos     = but_ext & lo_mask;
                addr_a  = ((but_ext & ~lo_mask) << 1) | pos;
                addr_b  = addr_a | LAYERS'(1 << l);
                tw_addr = ButtWL'(pos << (LAYERS - 1 - l));
            end
        end
    end

    assign bus.ADDR_A   = addr_a;
    assign bus.ADDR_B   = addr_b;
    assign bus.TW_ADDR  = tw_addr;
    assign bus.LAY_NUM  = lay_q;
    assign bus.BUT_NUM  = but_q;
    assign bus.LAY_DONE = lay_done_q;
    assign bus.LAST_LAY = (lay_q == LayWL'(LAYERS - 1));
    assign bus.DONE     = done_q;

endmodule

// File: tb/tb_addr_gen_fft_iter_resp.sv
// Directed bench for addr_gen_fft_iter_resp: expected output snapshots are queued by the stimulus and
// compared by an independent monitor when the stimulus signals an observation point.
module tb_addr_gen_fft_iter_resp;

    localparam int LAYERS = 5;
    localparam int BUTT   = 16;
    localparam int LayWL  = 3;
    localparam int ButtWL = 4;

    typedef struct packed {
        logic [LAYERS-1:0] a;
        logic [LAYERS-1:0] b;
        logic [ButtWL-1:0] tw;
        logic [LayWL-1:0]  lay;
        logic [ButtWL-1:0] but;
        logic              ld;
        logic              last;
        logic              done;
    } snap_t;

    logic CLK = 1'b0;
    logic RST = 1'b0;

    addr_gen_fft_iter_resp_if #(.LAYERS(LAYERS), .LayWL(LayWL), .ButtWL(ButtWL)) bus ();

    addr_gen_fft_iter_resp #(
        .LAYERS(LAYERS), .BUTTERFLYES(BUTT), .LayWL(LayWL), .ButtWL(ButtWL)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int    checks = 0;
    int    errors = 0;
    snap_t exp_q[$];
    event  mon_ev;
    string cur_name;

    // Coverage of A/B pairs per layer during one full transform.
    logic        cov_on = 1'b0;
    logic [31:0] cov_map [LAYERS];
    int          cov_dup = 0;

    // Monitor: pops the next expected snapshot and compares it against the live outputs.
    initial begin
        snap_t e, act;
        forever begin
            @(mon_ev);
            #1;
            act = '{a: bus.ADDR_A, b: bus.ADDR_B, tw: bus.TW_ADDR, lay: bus.LAY_NUM,
                    but: bus.BUT_NUM, ld: bus.LAY_DONE, last: bus.LAST_LAY, done: bus.DONE};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL %s: no expected entry queued", cur_name);
            end else begin
                e = exp_q.pop_front();
                if (act !== e) begin
                    errors++;
                    $display("FAIL %s: got A=%0d B=%0d TW=%0d LAY=%0d BUT=%0d LD=%0b LAST=%0b DONE=%0b want A=%0d B=%0d TW=%0d LAY=%0d BUT=%0d LD=%0b LAST=%0b DONE=%0b",
                             cur_name, act.a, act.b, act.tw, act.lay, act.but, act.ld, act.last, act.done,
                             e.a, e.b, e.tw, e.lay, e.but, e.ld, e.last, e.done);
                end
            end
        end
    end

    task automatic expect_snap(input string name, input int a, input int b, input int tw, input int lay,
                               input int but, input bit ld, input bit last, input bit done);
        snap_t e;
        e = '{a: LAYERS'(a), b: LAYERS'(b), tw: ButtWL'(tw), lay: LayWL'(lay),
              but: ButtWL'(but), ld: ld, last: last, done: done};
        cur_name = name;
        exp_q.push_back(e);
        -> mon_ev;
        #2;
    endtask

    // n back-to-back advance strobes; returns at a falling edge with ADDR_EN low.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            bus.ADDR_EN = 1'b1;
            if (cov_on && !bus.DONE) begin
                #1;
                if (cov_map[bus.LAY_NUM][bus.ADDR_A]) cov_dup++;
                cov_map[bus.LAY_NUM][bus.ADDR_A] = 1'b1;
                if (cov_map[bus.LAY_NUM][bus.ADDR_B]) cov_dup++;
                cov_map[bus.LAY_NUM][bus.ADDR_B] = 1'b1;
            end
        end
        @(negedge CLK);
        bus.ADDR_EN = 1'b0;
    endtask

    task automatic clear_pos();
        @(negedge CLK);
        bus.ADDR_RST = 1'b1;
        @(negedge CLK);
        bus.ADDR_RST = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.EN       = 1'b1;
        bus.ADDR_RST = 1'b0;
        bus.ADDR_EN  = 1'b0;
        for (int l = 0; l < LAYERS; l++) cov_map[l] = '0;

        // Reset
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        expect_snap("reset", 0, 1, 0, 0, 0, 0, 0, 0);

        // Layer 0 decode
        step(5);
        expect_snap("l0_b5", 10, 11, 0, 0, 5, 0, 0, 0);

        // Layer wrap after 16 strobes; pulse lasts exactly one cycle
        step(11);
        expect_snap("wrap_pulse", 0, 2, 0, 1, 0, 1, 0, 0);
        @(negedge CLK);
        expect_snap("wrap_pulse_end", 0, 2, 0, 1, 0, 0, 0, 0);
        step(5);
        expect_snap("l1_b5", 9, 11, 8, 1, 5, 0, 0, 0);

        // Full transform with address coverage
        clear_pos();
        expect_snap("clear_mid", 0, 1, 0, 0, 0, 0, 0, 0);
        cov_on = 1'b1;
        step(69);
        expect_snap("l4_b5", 5, 21, 5, 4, 5, 0, 1, 0);
        step(11);
        cov_on = 1'b0;
        expect_snap("done_pulse", 0, 16, 0, 4, 0, 1, 1, 1);
        @(negedge CLK);
        expect_snap("done_hold", 0, 16, 0, 4, 0, 0, 1, 1);
        for (int l = 0; l < LAYERS; l++) begin
            checks++;
            if (cov_map[l] !== 32'hFFFF_FFFF) begin
                errors++;
                $display("FAIL cover_l%0d: got map %h want ffffffff", l, cov_map[l]);
            end
        end
        checks++;
        if (cov_dup != 0) begin
            errors++;
            $display("FAIL cover_dup: got %0d duplicate addresses want 0", cov_dup);
        end

        // Strobe after completion is ignored
        step(1);
        expect_snap("done_ignore", 0, 16, 0, 4, 0, 0, 1, 1);
        clear_pos();
        expect_snap("done_clear", 0, 1, 0, 0, 0, 0, 0, 0);

        // ADDR_RST beats a simultaneous ADDR_EN
        step(7);
        expect_snap("l0_b7", 14, 15, 0, 0, 7, 0, 0, 0);
        @(negedge CLK);
        bus.ADDR_RST = 1'b1;
        bus.ADDR_EN  = 1'b1;
        @(negedge CLK);
        bus.ADDR_RST = 1'b0;
        bus.ADDR_EN  = 1'b0;
        expect_snap("rst_over_en", 0, 1, 0, 0, 0, 0, 0, 0);

        // EN low freezes everything, ADDR_RST included
        step(3);
        expect_snap("pre_freeze", 6, 7, 0, 0, 3, 0, 0, 0);
        bus.EN = 1'b0;
        step(4);
        clear_pos();
        expect_snap("freeze", 6, 7, 0, 0, 3, 0, 0, 0);
        bus.EN = 1'b1;

        // Asynchronous reset at layer 2, observed before the next clock edge
        clear_pos();
        step(35);
        expect_snap("l2_b3", 3, 7, 12, 2, 3, 0, 0, 0);
        @(negedge CLK);
        #1;
        RST = 1'b0;
        expect_snap("async_rst", 0, 1, 0, 0, 0, 0, 0, 0);
        @(negedge CLK);
        RST = 1'b1;

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d leftover entries want 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
